// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read engine and its output buffer.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    // Two entries let the buffer absorb one in-flight word while the head
    // waits on the sink, which is what keeps the stream at one word per cycle.
    localparam int MIN_BUF_DEPTH = 2;

endpackage

// File: rtl/rd_out_buf.sv
// Small register FIFO sitting between the FIFO read data and the stream port.
// Entry 0 is always the head, so the head output comes straight from a flop.
module rd_out_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CNT_W-1:0]      count,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] entries_q [DEPTH];
    logic [DATA_WIDTH-1:0] entries_d [DEPTH];
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  do_pop;
    logic                  do_push;
    logic [CNT_W-1:0]      wr_idx;

    // Shift toward the head on pop, then drop the new word just behind the last valid entry.
    always_comb begin
        do_pop    = pop && (count_q != '0);
        wr_idx    = count_q - CNT_W'(do_pop);
        do_push   = push && (wr_idx < CNT_W'(DEPTH));
        entries_d = entries_q;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                entries_d[i] = entries_q[i + 1];
            end
            entries_d[DEPTH - 1] = '0;
        end
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    entries_d[i] = push_data;
                end
            end
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage and occupancy registers; reset empties the buffer and zeroes the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

    assign head  = entries_q[0];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/fifo_read_engine.sv
// Read-side agent for the synchronous FIFO: issues a burst of reads, never
// reading an empty FIFO, and streams the captured words out on valid/ready.
module fifo_read_engine
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  abort,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  err_underflow,
    output logic [LEN_WIDTH-1:0]  words_read
);

    // A smaller buffer could not cover the read-to-capture latency, so clamp it.
    localparam int DEPTH = (BUF_DEPTH < MIN_BUF_DEPTH) ? MIN_BUF_DEPTH : BUF_DEPTH;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    rd_state_t            state_q;
    rd_state_t            state_d;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic [LEN_WIDTH-1:0] remaining_d;
    logic [LEN_WIDTH-1:0] words_read_q;
    logic [LEN_WIDTH-1:0] words_read_d;
    logic                 inflight_q;
    logic                 inflight_d;
    logic                 aborted_q;
    logic                 aborted_d;
    logic                 err_underflow_q;
    logic                 err_underflow_d;

    logic                 rd_en;
    logic                 pop;
    logic                 buf_empty;
    logic [CNT_W-1:0]     buf_count;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [OCC_W-1:0]     occupancy;
    logic                 busy_int;

    assign busy_int = (state_q == READ) || (state_q == DRAIN);
    assign pop      = !buf_empty && m_ready;

    rd_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_rdata),
        .pop       (pop),
        .head      (buf_head),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    // Launch a read only if the FIFO has data and the word will have a buffer slot when it lands.
    always_comb begin
        occupancy = OCC_W'(buf_count) + OCC_W'(inflight_q) - OCC_W'(pop);
        rd_en     = (state_q == READ) && !rst && !abort && !fifo_empty &&
                    (remaining_q != '0) && (occupancy < OCC_W'(DEPTH));
    end

    // Burst sequencing plus the word counter and sticky status flags.
    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        inflight_d      = rd_en;
        aborted_d       = aborted_q;
        err_underflow_d = err_underflow_q | (fifo_underflow && busy_int);
        words_read_d    = words_read_q;
        if (pop && (words_read_q != {LEN_WIDTH{1'b1}})) begin
            words_read_d = words_read_q + LEN_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    words_read_d    = '0;
                    aborted_d       = 1'b0;
                    err_underflow_d = 1'b0;
                    if (len != '0) begin
                        remaining_d = len;
                        state_d     = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                if (rd_en) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                end
                if (abort) begin
                    aborted_d   = 1'b1;
                    remaining_d = '0;
                    state_d     = DRAIN;
                end else if (remaining_d == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Finish as soon as the last buffered word is leaving this cycle.
                if (!inflight_q && (buf_count == CNT_W'(pop))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            aborted_q       <= 1'b0;
            err_underflow_q <= 1'b0;
            words_read_q    <= '0;
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            aborted_q       <= aborted_d;
            err_underflow_q <= err_underflow_d;
            words_read_q    <= words_read_d;
        end
    end

    assign fifo_rd_en    = rd_en;
    assign m_valid       = !buf_empty;
    assign m_data        = buf_head;
    assign busy          = busy_int;
    assign done          = (state_q == DONE);
    assign aborted       = aborted_q;
    assign err_underflow = err_underflow_q;
    assign words_read    = words_read_q;

endmodule

// File: tb/tb_fifo_read_engine.sv
// Self-checking bench for fifo_read_engine: a queue-based FIFO model feeds the
// DUT and every word read from it must reappear on the stream in order.
module tb_fifo_read_engine;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam int BD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          abort;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_underflow;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          err_underflow;
    logic [LW-1:0] words_read;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q [$];
    int reads_total = 0;
    int delivered_total = 0;
    int done_total = 0;
    logic neg_rd = 1'b0;
    logic neg_rst = 1'b0;
    logic hold_valid = 1'b0;
    logic [DW-1:0] hold_data = '0;

    int base_rd;
    int base_del;
    int base_done;
    int n_rd;
    int rlen;
    int pushed;
    logic [DW-1:0] t1 [4];

    fifo_read_engine #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .BUF_DEPTH  (BD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .len            (len),
        .abort          (abort),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_rdata     (fifo_rdata),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .err_underflow  (err_underflow),
        .words_read     (words_read)
    );

    always #5 clk = ~clk;

    // FIFO model: pops on a read seen in the previous half cycle; read data lands one cycle later.
    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (neg_rd && fifo_q.size() != 0) begin
            w = fifo_q.pop_front();
            fifo_rdata <= w;
            reads_total++;
            if (!neg_rst) exp_q.push_back(w);
        end
        if (neg_rst) exp_q.delete();
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Mid-cycle monitor: read legality, stream ordering and stall stability.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        neg_rd  = fifo_rd_en;
        neg_rst = rst;
        checks++;
        assert (!(fifo_rd_en === 1'b1 && fifo_empty === 1'b1)) else begin
            failures++;
            $error("FAIL rd_while_empty observed=1 expected=0");
        end
        checks++;
        assert (!(fifo_rd_en === 1'b1 && busy !== 1'b1)) else begin
            failures++;
            $error("FAIL rd_while_not_busy observed=1 expected=0");
        end
        if (hold_valid) begin
            checks++;
            assert (m_valid === 1'b1 && m_data === hold_data) else begin
                failures++;
                $error("FAIL stall_stable observed=%0b/%0h expected=1/%0h", m_valid, m_data, hold_data);
            end
        end
        if (m_valid === 1'b1 && m_ready && !rst) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL phantom_word observed=%0h expected=none", m_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (m_data === e) else begin
                    failures++;
                    $error("FAIL stream_order observed=%0h expected=%0h", m_data, e);
                end
            end
            delivered_total++;
        end
        hold_valid = (m_valid === 1'b1) && !m_ready && !rst;
        hold_data  = m_data;
        if (done === 1'b1) done_total++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus_preload(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'($urandom));
    endtask

    task automatic mark_bases();
        base_rd   = reads_total;
        base_del  = delivered_total;
        base_done = done_total;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
        t1[0] = 8'hA1; t1[1] = 8'hA2; t1[2] = 8'hA3; t1[3] = 8'hA4;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_output("rst_rd_en", fifo_rd_en, 0);
        check_output("rst_m_valid", m_valid, 0);
        check_output("rst_m_data", m_data, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_aborted", aborted, 0);
        check_output("rst_err", err_underflow, 0);
        check_output("rst_words", words_read, 0);
        next_cycle();
        rst = 1'b0;

        $display("[TB] test 1: preloaded burst of 4");
        for (int i = 0; i < 4; i++) fifo_q.push_back(t1[i]);
        next_cycle();
        mark_bases();
        m_ready = 1'b1; start = 1'b1; len = 8'd4;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            check_output($sformatf("t1_rd_en_c%0d", c), fifo_rd_en, (c >= 1 && c <= 4));
            check_output($sformatf("t1_valid_c%0d", c), m_valid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check_output($sformatf("t1_data_c%0d", c), m_data, t1[c-3]);
            check_output($sformatf("t1_done_c%0d", c), done, (c == 7));
            check_output($sformatf("t1_busy_c%0d", c), busy, (c >= 1 && c <= 6));
            next_cycle();
            start = 1'b0;
        end
        check_output("t1_words", words_read, 4);
        check_output("t1_aborted", aborted, 0);
        check_output("t1_done_count", done_total - base_done, 1);

        $display("[TB] test 2: zero-length burst");
        mark_bases();
        start = 1'b1; len = 8'd0;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            check_output($sformatf("t2_rd_en_c%0d", c), fifo_rd_en, 0);
            check_output($sformatf("t2_busy_c%0d", c), busy, 0);
            check_output($sformatf("t2_done_c%0d", c), done, (c == 1));
            next_cycle();
            start = 1'b0;
        end
        check_output("t2_words", words_read, 0);
        check_output("t2_reads", reads_total - base_rd, 0);

        $display("[TB] test 3: burst from an empty FIFO");
        mark_bases();
        start = 1'b1; len = 8'd3;
        for (int c = 1; c < 400; c++) begin
            next_cycle();
            start = 1'b0;
            if (c == 10) fifo_q.push_back(8'h11);
            if (c == 15) fifo_q.push_back(8'h22);
            if (c == 20) fifo_q.push_back(8'h33);
            if (done === 1'b1) break;
        end
        check_output("t3_done_seen", done, 1);
        check_output("t3_words", words_read, 3);
        check_output("t3_delivered", delivered_total - base_del, 3);
        check_output("t3_err", err_underflow, 0);
        next_cycle();

        $display("[TB] test 4: sink stalled for ten cycles");
        apply_stimulus_preload(8);
        next_cycle();
        mark_bases();
        m_ready = 1'b0; start = 1'b1; len = 8'd8;
        for (int c = 1; c < 400; c++) begin
            next_cycle();
            start = (c == 12);
            len = (c == 12) ? 8'd3 : 8'd8;
            if (c == 10) begin
                check_output("t4_reads_before_ready", reads_total - base_rd, BD);
                m_ready = 1'b1;
            end
            if (done === 1'b1) break;
        end
        start = 1'b0;
        check_output("t4_done_seen", done, 1);
        check_output("t4_words", words_read, 8);
        check_output("t4_delivered", delivered_total - base_del, 8);
        repeat (3) next_cycle();
        check_output("t4_done_once", done_total - base_done, 1);

        $display("[TB] test 5: abort mid-burst");
        apply_stimulus_preload(8);
        next_cycle();
        mark_bases();
        start = 1'b1; len = 8'd8;
        for (int c = 1; c < 400; c++) begin
            next_cycle();
            start = 1'b0;
            abort = (c == 4);
            if (done === 1'b1) break;
        end
        abort = 1'b0;
        n_rd = reads_total - base_rd;
        check_output("t5_done_seen", done, 1);
        check_output("t5_reads_le4", (n_rd <= 4), 1);
        check_output("t5_delivered", delivered_total - base_del, n_rd);
        check_output("t5_words", words_read, n_rd);
        check_output("t5_aborted", aborted, 1);
        check_output("t5_fifo_left", fifo_q.size(), 8 - n_rd);
        fifo_q.delete();
        next_cycle();
        next_cycle();

        $display("[TB] test 5b: underflow flag, ignored abort, sticky clear");
        apply_stimulus_preload(2);
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        start = 1'b1; len = 8'd2;
        for (int c = 1; c < 400; c++) begin
            next_cycle();
            start = 1'b0;
            fifo_underflow = (c == 2);
            if (done === 1'b1) break;
        end
        fifo_underflow = 1'b0;
        check_output("t5b_done_seen", done, 1);
        check_output("t5b_err_set", err_underflow, 1);
        check_output("t5b_aborted_clear", aborted, 0);
        next_cycle();
        fifo_underflow = 1'b1;
        next_cycle();
        fifo_underflow = 1'b0;
        check_output("t5b_err_sticky", err_underflow, 1);
        start = 1'b1; len = 8'd0;
        next_cycle();
        start = 1'b0;
        check_output("t5b_err_cleared", err_underflow, 0);
        next_cycle();

        $display("[TB] test 6: reset mid-burst");
        apply_stimulus_preload(8);
        next_cycle();
        start = 1'b1; len = 8'd8;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            start = 1'b0;
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_output("t6_valid", m_valid, 0);
        check_output("t6_rd_en", fifo_rd_en, 0);
        check_output("t6_busy", busy, 0);
        check_output("t6_done", done, 0);
        check_output("t6_words", words_read, 0);
        fifo_q.delete();
        next_cycle();
        apply_stimulus_preload(4);
        next_cycle();
        mark_bases();
        start = 1'b1; len = 8'd4;
        for (int c = 1; c < 400; c++) begin
            next_cycle();
            start = 1'b0;
            if (done === 1'b1) break;
        end
        check_output("t6_restart_done", done, 1);
        check_output("t6_restart_words", words_read, 4);
        check_output("t6_restart_delivered", delivered_total - base_del, 4);
        next_cycle();

        $display("[TB] random bursts");
        for (int b = 0; b < 6; b++) begin
            rlen = $urandom_range(12, 1);
            pushed = 0;
            mark_bases();
            start = 1'b1; len = LW'(rlen);
            for (int c = 1; c < 600; c++) begin
                next_cycle();
                start = 1'b0;
                m_ready = ($urandom_range(3, 0) != 0);
                if (pushed < rlen && $urandom_range(1, 0) == 1) begin
                    fifo_q.push_back(DW'($urandom));
                    pushed++;
                end
                if (done === 1'b1) break;
            end
            check_output($sformatf("rnd%0d_done", b), done, 1);
            check_output($sformatf("rnd%0d_words", b), words_read, rlen);
            check_output($sformatf("rnd%0d_reads", b), reads_total - base_rd, rlen);
            check_output($sformatf("rnd%0d_delivered", b), delivered_total - base_del, rlen);
            check_output($sformatf("rnd%0d_err", b), err_underflow, 0);
            m_ready = 1'b1;
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
